// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Mirrors the pipeline-wide reset/stall/zero-word definitions.
package if_fetch_unit_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W_DEF  = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned STALL_W     = 6;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam logic [INST_W_DEF-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Byte-wide read port between the fetch stage (master) and the memory/UART controller (slave).
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_rvalid
  );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: assembles 32-bit instructions from four little-endian byte reads
// and presents them to if_id, honouring ctrl stalls and id-stage branch redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_W,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  if_fetch_unit_if.master    mem,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INST_W-1:0]  if_inst,
  output logic               if_valid,
  output logic               stallreq_if
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       buf_q, buf_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic              valid_q, valid_d;
  logic              stallreq_q;

  logic outstanding;
  logic consume;
  logic unused_stall;

  assign unused_stall = ^stall[STALL_W-1:2];
  assign outstanding  = req_q || (state_q == DRAIN);
  assign consume      = (stall[1] == NO_STOP) && (stall[0] == NO_STOP);

  // Next-state, byte assembly and output-register update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    req_d      = req_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    valid_d    = valid_q;

    if (branch_flag) begin
      pc_d       = branch_target;
      cnt_d      = 2'd0;
      buf_d      = '0;
      valid_d    = 1'b0;
      out_pc_d   = '0;
      out_inst_d = INST_W'(ZERO_WORD);
      // A byte still in flight must be swallowed before re-requesting.
      if (outstanding && !mem.mem_rvalid) begin
        state_d = DRAIN;
        req_d   = 1'b0;
      end else begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_d = 1'b1;
          end else if (mem.mem_rvalid) begin
            if (cnt_q == 2'd3) begin
              out_inst_d = INST_W'({mem.mem_rdata, buf_q});
              out_pc_d   = pc_q;
              valid_d    = 1'b1;
              pc_d       = pc_q + ADDR_W'(4);
              cnt_d      = 2'd0;
              state_d    = HOLD;
              req_d      = 1'b0;
            end else begin
              case (cnt_q)
                2'd0:    buf_d[7:0]   = mem.mem_rdata;
                2'd1:    buf_d[15:8]  = mem.mem_rdata;
                default: buf_d[23:16] = mem.mem_rdata;
              endcase
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        DRAIN: begin
          if (mem.mem_rvalid) begin
            state_d = FETCH;
            req_d   = 1'b1;
          end
        end
        HOLD: begin
          if (consume) begin
            valid_d    = 1'b0;
            out_pc_d   = '0;
            out_inst_d = INST_W'(ZERO_WORD);
            state_d    = FETCH;
            req_d      = 1'b1;
          end
        end
        default: begin
          state_d = FETCH;
          req_d   = 1'b0;
        end
      endcase
    end

    addr_d = pc_d + ADDR_W'(cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      buf_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      out_pc_q   <= '0;
      out_inst_q <= INST_W'(ZERO_WORD);
      valid_q    <= 1'b0;
      stallreq_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
      valid_q    <= valid_d;
      stallreq_q <= (state_d != HOLD);
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign if_pc        = out_pc_q;
  assign if_inst      = out_inst_q;
  assign if_valid     = valid_q;
  assign stallreq_if  = stallreq_q;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. It is the producer side of the if/id pipeline-register interface and drives if_pc/if_inst into if_id.
- Fetches 32-bit instructions from the byte-wide memory/UART controller in four little-endian byte reads, then presents each assembled instruction until if_id consumes it.
- Handles ctrl stall bits and id-stage branch redirects, including discarding a memory byte that is already in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC/memory address width (`InstAddrBus).
- INST_W, 32, instruction width (`InstBus); fixed at 4 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  ctrl stall vector. stall[0] freezes the PC stage; stall[1] freezes if_id.
- branch_flag  in  1  one-cycle redirect pulse from id
- branch_target  in  32  redirect PC
- mem_req  out  1  byte read request; held until mem_rvalid
- mem_addr  out  32  byte address; stable while mem_req is high
- mem_rdata  in  8  returned byte
- mem_rvalid  in  1  mem_rdata valid; 1 pulse per request, at least 1 cycle after mem_req rises
- if_pc  out  32  PC of the presented instruction; `ZeroWord when not valid
- if_inst  out  32  presented instruction; `ZeroWord when not valid (bubble)
- if_valid  out  1  if_pc/if_inst hold a real instruction
- stallreq_if  out  1  to ctrl; high while no valid instruction is available

Behaviour:
- Reset (rst==`RstEnable at posedge):
  - pc=RESET_PC, state=FETCH, byte_cnt=0, inst buffer=0.
  - if_valid=0, if_pc=if_inst=`ZeroWord, mem_req=0, stallreq_if=1.
  - Reset overrides everything, including mid-fetch. An rvalid arriving after reset is ignored only if it was issued before reset; the controller is reset by the same rst.
- States: FETCH, DRAIN, HOLD.
- FETCH:
  - mem_req=1, mem_addr=pc+byte_cnt (mod 2^32, wraps).
  - On mem_rvalid: buf[8*byte_cnt +: 8]=mem_rdata, byte_cnt++. The next request is issued on the following cycle with the new address.
  - When byte_cnt==3 and mem_rvalid arrive together, the next posedge registers:
    - if_inst = {mem_rdata, buf[23:0]}, if_pc = pc, if_valid = 1.
    - pc = pc+4, byte_cnt = 0.
    - state = HOLD, mem_req = 0.
- HOLD:
  - Outputs are stable, mem_req=0, stallreq_if=0.
  - Consume condition: stall[1]==`NoStop and stall[0]==`NoStop.
  - On consume at a posedge: if_valid=0, outputs=`ZeroWord, state=FETCH. The first byte request is issued the cycle after consumption.
  - While either stall bit is `Stop: stay in HOLD with outputs unchanged.
- stallreq_if = (state != HOLD).
- Latency: with single-cycle rvalid, a memory round trip is req→rvalid in 1 cycle. A 4-byte fetch is then 8 cycles from entering FETCH to if_valid high.
- Branch redirect (branch_flag==1 at posedge), highest priority after reset:
  - pc=branch_target, byte_cnt=0, if_valid=0, outputs=`ZeroWord.
  - If mem_req is outstanding and mem_rvalid is not in the same cycle, go to DRAIN. Otherwise go to FETCH.
  - A byte arriving in the same cycle as branch_flag is discarded.
  - In HOLD, a redirect drops the held instruction; no memory request is outstanding, so go to FETCH.
- DRAIN:
  - mem_req=0; wait for mem_rvalid, discard the byte, then go to FETCH (new request next cycle).
  - A branch_flag during DRAIN updates pc again and stays in DRAIN.
- Stall in FETCH: an outstanding byte request is never aborted by stall. Bytes continue to be collected and the completed instruction waits in HOLD.
- branch_target is not required to be aligned. Byte addresses are pc..pc+3; no misalignment trap.
- No combinational path from mem_rvalid to mem_req. mem_req is a registered output.

Decomposition:
- Shared defines header (existing defines.v): `RstEnable, `Stop/`NoStop, `ZeroWord, `InstAddrBus, `InstBus.
- Add FETCH/DRAIN/HOLD state encodings (2-bit) to the shared header.
- No sub-module. Byte assembly is a 24-bit shift/index register inside the block.

Test Plan:
- Reset then fetch:
  - Stimulus: memory bytes at 0..3 = 13,05,A0,00; rvalid 1 cycle after req; stall=0.
  - Required: mem_addr sequence 0,1,2,3; if_valid=1 with if_inst=32'h00A00513, if_pc=0 eight cycles after reset release.
  - Required: next fetch starts at address 4.
- Stall hold:
  - Stimulus: stall=6'b000011 when the instruction completes, held for 5 cycles.
  - Required: if_inst/if_pc stable and mem_req=0 for all 5 cycles; on release, consumed, and mem_addr=4 requested on the following cycle.
- Redirect mid-fetch with pending byte:
  - Stimulus: branch_flag pulse with target 32'h100 while waiting on the rvalid for byte 1.
  - Required: DRAIN entered, that byte is discarded, next mem_addr=32'h100, and if_inst is assembled only from bytes at 100..103.
- Redirect coincident with rvalid:
  - Stimulus: branch_flag and mem_rvalid in the same cycle, target 32'h40.
  - Required: no DRAIN, mem_addr=32'h40 on the next cycle, discarded byte absent from the result.
- Reset mid-fetch:
  - Stimulus: rst asserted after byte 2 returns.
  - Required: next cycle if_valid=0, outputs=0, mem_req=0, pc=RESET_PC; fresh fetch from byte 0 after release.
- Address wrap:
  - Stimulus: branch_target=32'hFFFF_FFFE.
  - Required: mem_addr sequence FFFF_FFFE, FFFF_FFFF, 0, 1; next pc=32'h0000_0002.
